// File: rtl/i2lbs_pkg.sv
// Shared types for the I2LBS candidate scheduler: FSM states, coordinate pair, default width.
package i2lbs_pkg;

    localparam int DEF_DATA_WIDTH_12 = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH_12-1:0] x;
        logic [DEF_DATA_WIDTH_12-1:0] y;
    } coord_t;

endpackage

// File: rtl/i2lbs_candidate_fifo.sv
// Candidate queue: power-of-two depth, wrapping pointers, occupancy count one bit wider than the pointers.
module i2lbs_candidate_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2lbs_candidate_scheduler.sv
// Queues first-phase face candidates and runs each through the second-phase classifier.
// Optional I2LBS_SCHED_STATS_EN adds saturating accept/drop counters.
module i2lbs_candidate_scheduler
    import i2lbs_pkg::*;
#(
    parameter int DATA_WIDTH_12  = DEF_DATA_WIDTH_12,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     first_phase_candidate,
    input  logic [DATA_WIDTH_12-1:0] scale_xcoord,
    input  logic [DATA_WIDTH_12-1:0] scale_ycoord,
    output logic                     sp_start,
    output logic [DATA_WIDTH_12-1:0] sp_xcoord,
    output logic [DATA_WIDTH_12-1:0] sp_ycoord,
    input  logic                     sp_done,
    input  logic                     sp_candidate,
    output logic                     o_face_valid,
    output logic [DATA_WIDTH_12-1:0] o_face_x,
    output logic [DATA_WIDTH_12-1:0] o_face_y,
    output logic                     o_busy,
    output logic                     o_overflow,
    output logic                     o_timeout
`ifdef I2LBS_SCHED_STATS_EN
    ,
    output logic [15:0]              o_cnt_accept,
    output logic [15:0]              o_cnt_drop
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    sched_state_e             state_q, state_d;
    logic [TW-1:0]            wcnt_q, wcnt_d;
    logic [DATA_WIDTH_12-1:0] spx_q, spy_q;
    logic                     ovf_q, to_q, to_d;
    logic                     pop, push, drop, full, empty;
    logic [2*DATA_WIDTH_12-1:0] head;

    assign push = first_phase_candidate && (!full || pop);
    assign drop = first_phase_candidate && full && !pop;

    i2lbs_candidate_fifo #(
        .WIDTH (2*DATA_WIDTH_12),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_fpga),
        .rst_i   (reset_fpga),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({scale_xcoord, scale_ycoord}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pop     = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = START;
            end
            START: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            // A completion landing on the last allowed cycle beats the timeout.
            WAIT: if (sp_done) begin
                state_d = sp_candidate ? REPORT : IDLE;
            end else if (wcnt_q == TMAX) begin
                to_d    = 1'b1;
                state_d = IDLE;
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            spx_q   <= '0;
            spy_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            to_q    <= to_d;
            if (drop) ovf_q <= 1'b1;
            if (pop) begin
                spx_q <= head[2*DATA_WIDTH_12-1:DATA_WIDTH_12];
                spy_q <= head[DATA_WIDTH_12-1:0];
            end
        end
    end

    assign sp_start     = (state_q == START);
    assign sp_xcoord    = spx_q;
    assign sp_ycoord    = spy_q;
    assign o_face_valid = (state_q == REPORT);
    assign o_face_x     = o_face_valid ? spx_q : '0;
    assign o_face_y     = o_face_valid ? spy_q : '0;
    assign o_busy       = (state_q != IDLE) || !empty;
    assign o_overflow   = ovf_q;
    assign o_timeout    = to_q;

`ifdef I2LBS_SCHED_STATS_EN
    logic [15:0] acc_q, drp_q;

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            acc_q <= '0;
            drp_q <= '0;
        end else begin
            if (push && acc_q != 16'hFFFF) acc_q <= acc_q + 1'b1;
            if (drop && drp_q != 16'hFFFF) drp_q <= drp_q + 1'b1;
        end
    end

    assign o_cnt_accept = acc_q;
    assign o_cnt_drop   = drp_q;
`endif

endmodule

// File: doc/i2lbs_candidate_scheduler.md
I2LBS_CANDIDATE_SCHEDULER -- requirements
Module: i2lbs_candidate_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH_12, default 12, giving the coordinate width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of candidate entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum wait for sp_done.
REQ-004 SHALL have port clk_fpga, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset_fpga, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port first_phase_candidate, input, 1 bit: one-cycle pulse marking a first-phase pass.
REQ-007 SHALL have ports scale_xcoord and scale_ycoord, input, DATA_WIDTH_12 bits each: window coordinates, valid with first_phase_candidate.
REQ-008 SHALL have port sp_start, output, 1 bit: one-cycle launch pulse to the second-phase classifier.
REQ-009 SHALL have ports sp_xcoord and sp_ycoord, output, DATA_WIDTH_12 bits each: coordinates of the window under second-phase evaluation.
REQ-010 SHALL have port sp_done, input, 1 bit: second-phase completion pulse.
REQ-011 SHALL have port sp_candidate, input, 1 bit: second-phase verdict, valid with sp_done.
REQ-012 SHALL have ports o_face_valid (output, 1 bit) and o_face_x / o_face_y (output, DATA_WIDTH_12 bits each): one-cycle detection report.
REQ-013 SHALL have port o_busy, output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-014 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a candidate is dropped.
REQ-015 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a second-phase evaluation is aborted.

Function
REQ-016 SHALL write {x,y} into the FIFO on every clk_fpga edge where first_phase_candidate=1 and a slot is free.
- A slot counts as free if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-017 SHALL drop the candidate and set o_overflow when first_phase_candidate=1, the FIFO is full and no pop occurs that cycle.
REQ-018 SHALL implement the FSM IDLE -> START -> WAIT -> (REPORT | IDLE).
REQ-019 In IDLE with a non-empty FIFO, SHALL pop the head into the sp_xcoord/sp_ycoord registers and go to START.
REQ-020 START SHALL assert sp_start for exactly one cycle, then go to WAIT.
REQ-021 A candidate arriving into an empty FIFO with the FSM idle in cycle N SHALL produce sp_start high in cycle N+2.
REQ-022 In WAIT, sp_done=1 with sp_candidate=1 SHALL go to REPORT.
- REPORT SHALL assert o_face_valid for one cycle with o_face_x/o_face_y equal to sp_xcoord/sp_ycoord, then go to IDLE.
REQ-023 In WAIT, sp_done=1 with sp_candidate=0 SHALL go to IDLE with no report.
REQ-024 In WAIT, a wait counter SHALL increment every cycle.
- If the counter reaches TIMEOUT_CYCLES-1 without sp_done, the FSM SHALL pulse o_timeout, discard the window and go to IDLE.
- sp_done arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-025 sp_done outside WAIT SHALL be ignored.
REQ-026 sp_xcoord and sp_ycoord SHALL hold stable from START until the FSM next leaves IDLE.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked in a count of $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 While reset_fpga=1 at a clk_fpga edge, the block SHALL:
- clear the FIFO;
- go to IDLE;
- drive all outputs to 0 and clear o_overflow;
- ignore first_phase_candidate.
REQ-029 A reset asserted mid-evaluation SHALL abandon the evaluation; a later sp_done SHALL be ignored.

Configuration
REQ-030 When I2LBS_SCHED_STATS_EN is defined, the block SHALL add output ports o_cnt_accept and o_cnt_drop, 16 bits each.
- Both counters SHALL saturate at 16'hFFFF and reset to 0.
- o_cnt_accept counts FIFO writes; o_cnt_drop counts dropped candidates.
REQ-031 When I2LBS_SCHED_STATS_EN is undefined, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-032 A shared package i2lbs_pkg SHALL hold:
- the FSM state enum (IDLE, START, WAIT, REPORT);
- the coordinate struct {x, y};
- the default DATA_WIDTH_12 constant.
REQ-033 The FIFO SHALL be a sub-module named i2lbs_candidate_fifo, instantiated once.

Verification
REQ-034 Single candidate: candidate (x=5, y=7) in cycle 10 -> sp_start in cycle 12 with sp_x=5, sp_y=7; sp_done=1 and sp_candidate=1 in cycle 20 -> o_face_valid in cycle 21 with (5,7).
REQ-035 Overflow: with FIFO_DEPTH=4 and sp_done held low, 6 back-to-back candidates -> 1 dispatched, 4 queued, 1 dropped; o_overflow=1; o_cnt_drop=1 when STATS enabled.
REQ-036 Full plus pop: FIFO full and IDLE popping in the same cycle as a new candidate -> candidate accepted; o_overflow stays 0.
REQ-037 Timeout: TIMEOUT_CYCLES=16 with no sp_done -> o_timeout pulses 16 cycles after entering WAIT; the next queued candidate is dispatched.
REQ-038 Reject: sp_candidate=0 with sp_done -> no o_face_valid; FSM back in IDLE the next cycle.
REQ-039 Reset mid-WAIT: reset_fpga high for 1 cycle during WAIT, then sp_done -> no o_face_valid; o_busy=0.
